// File: rtl/pll_clk_switch_ctrl.sv
// pll_clk_switch_ctrl
// Drives the select and enable inputs of an external BUFGMUX_CTRL/BUFGCE tree
// for NUM_OUT output clocks and serves the PLL configuration register port.
// Each select change runs a glitch-safe gate -> switch -> ungate sequence.
// The raw PLL lock is synchronised and filtered before use.
// Optional feature macro: PLL_CFG_STICKY_UNLOCK_EN (STATUS bit31 sticky unlock flag).
module pll_clk_switch_ctrl #(
    parameter int NUM_OUT    = 2,
    parameter int NUM_SRC    = 5,
    parameter int SEL_W      = $clog2(NUM_SRC),
    parameter int RESET_SEL  = 0,
    parameter int LOCK_CNT   = 16,
    parameter int GATE_CYC   = 4,
    parameter int SWITCH_CYC = 4
) (
    input  logic                     ref_clk_i,
    input  logic                     rst_glob_i,
    input  logic                     pll_lock_i,
    input  logic                     cfg_req_i,
    output logic                     cfg_ack_o,
    input  logic [3:0]               cfg_add_i,
    input  logic                     cfg_wrn_i,
    input  logic [31:0]              cfg_data_i,
    output logic [31:0]              cfg_r_data_o,
    output logic                     cfg_lock_o,
    output logic [NUM_OUT*SEL_W-1:0] clk_sel_o,
    output logic [NUM_OUT-1:0]       clk_ce_o
);

    localparam int LCK_W   = $clog2(LOCK_CNT + 1);
    localparam int CYC_MAX = (GATE_CYC > SWITCH_CYC) ? GATE_CYC : SWITCH_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_SWITCH
    } ch_state_t;

    logic [1:0]       sync;
    logic [LCK_W-1:0] lock_cnt;
    logic [LCK_W-1:0] lock_cnt_next;
    logic             lock_next;
    logic             accept;
    logic             wr_en;
    logic [31:0]      rd_val;
    logic             sticky;

    ch_state_t        state        [NUM_OUT];
    ch_state_t        state_next   [NUM_OUT];
    logic [CYC_W-1:0] cnt          [NUM_OUT];
    logic [CYC_W-1:0] cnt_next     [NUM_OUT];
    logic [SEL_W-1:0] applied      [NUM_OUT];
    logic [SEL_W-1:0] applied_next [NUM_OUT];
    logic [SEL_W-1:0] target       [NUM_OUT];
    logic [NUM_OUT-1:0] ce_next;
    logic [NUM_OUT-1:0] busy;

    assign accept = cfg_req_i && !cfg_ack_o;
    assign wr_en  = accept && !cfg_wrn_i;

    // Lock filter: saturating count of consecutive synced-high cycles.
    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        lock_cnt_next = lock_cnt;
        if (!sync[1]) begin
            lock_cnt_next = '0;
        end else if (lock_cnt != LCK_W'(LOCK_CNT)) begin
            lock_cnt_next = lock_cnt + LCK_W'(1);
        end
        lock_next = (lock_cnt_next == LCK_W'(LOCK_CNT));
    end

    // Lock synchroniser, counter and filtered lock register.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
        if (rst_glob_i) begin
            sync       <= '0;
            lock_cnt   <= '0;
            cfg_lock_o <= 1'b0;
        end else begin
            sync       <= {sync[0], pll_lock_i};
            lock_cnt   <= lock_cnt_next;
            cfg_lock_o <= lock_next;
        end
    end

    // Per-channel busy: sequence running or a new target still pending.
    always_comb begin
        busy = '0;
        for (int n = 0; n < NUM_OUT; n++) begin
            busy[n] = (state[n] != ST_IDLE) || (target[n] != applied[n]);
        end
    end

    // Register read mux, sampled into cfg_r_data_o on an accepted read.
    always_comb begin
        rd_val = '0;
        if (cfg_add_i == 4'd0) begin
            rd_val[0]         = cfg_lock_o;
            rd_val[NUM_OUT:1] = busy;
            rd_val[31]        = sticky;
        end else begin
            for (int n = 0; n < NUM_OUT; n++) begin
                if (cfg_add_i == 4'(n + 1)) begin
                    rd_val[SEL_W-1:0] = target[n];
                end
            end
        end
    end

    // Handshake, read data and per-channel target registers.
    // NOTE: the target array is only NUM_OUT entries of flops, so it is reset like any other register.
    always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
        if (rst_glob_i) begin
            cfg_ack_o    <= 1'b0;
            cfg_r_data_o <= '0;
            for (int n = 0; n < NUM_OUT; n++) begin
                target[n] <= SEL_W'(RESET_SEL);
            end
        end else begin
            cfg_ack_o <= accept;
            if (accept && cfg_wrn_i) begin
                cfg_r_data_o <= rd_val;
            end
            for (int n = 0; n < NUM_OUT; n++) begin
                if (wr_en && cfg_add_i == 4'(n + 1) && cfg_data_i < 32'(NUM_SRC)) begin
                    target[n] <= cfg_data_i[SEL_W-1:0];
                end
            end
        end
    end

`ifdef PLL_CFG_STICKY_UNLOCK_EN
    logic lock_fall;
    assign lock_fall = cfg_lock_o && !lock_next;

    // Sticky unlock flag: set on a falling filtered lock, cleared by a STATUS write.
    always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
        if (rst_glob_i) begin
            sticky <= 1'b0;
        end else begin
            if (wr_en && cfg_add_i == 4'd0) begin
                sticky <= 1'b0;
            end
            if (lock_fall) begin
                sticky <= 1'b1;
            end
        end
    end
`else
    assign sticky = 1'b0;
`endif

    // Per-channel switch FSM next state: gate CE, change select, hold, ungate.
    always_comb begin
        for (int n = 0; n < NUM_OUT; n++) begin
            state_next[n]   = state[n];
            cnt_next[n]     = cnt[n];
            applied_next[n] = applied[n];
            ce_next[n]      = 1'b0;
            case (state[n])
                ST_IDLE: begin
                    ce_next[n] = cfg_lock_o;
                    if (target[n] != applied[n] && cfg_lock_o) begin
                        state_next[n] = ST_GATE;
                        cnt_next[n]   = '0;
                        ce_next[n]    = 1'b0;
                    end
                end
                ST_GATE: begin
                    if (cnt[n] == CYC_W'(GATE_CYC - 1)) begin
                        applied_next[n] = target[n];
                        state_next[n]   = ST_SWITCH;
                        cnt_next[n]     = '0;
                    end else begin
                        cnt_next[n] = cnt[n] + CYC_W'(1);
                    end
                end
                ST_SWITCH: begin
                    if (cnt[n] == CYC_W'(SWITCH_CYC - 1)) begin
                        state_next[n] = ST_IDLE;
                        cnt_next[n]   = '0;
                        ce_next[n]    = cfg_lock_o;
                    end else begin
                        cnt_next[n] = cnt[n] + CYC_W'(1);
                    end
                end
                default: state_next[n] = ST_IDLE;
            endcase
        end
    end

    // Per-channel FSM state, counter, applied select and CE registers.
    always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
        if (rst_glob_i) begin
            for (int n = 0; n < NUM_OUT; n++) begin
                state[n]   <= ST_IDLE;
                cnt[n]     <= '0;
                applied[n] <= SEL_W'(RESET_SEL);
            end
            clk_ce_o <= '0;
        end else begin
            for (int n = 0; n < NUM_OUT; n++) begin
                state[n]   <= state_next[n];
                cnt[n]     <= cnt_next[n];
                applied[n] <= applied_next[n];
            end
            clk_ce_o <= ce_next;
        end
    end

    // Pack applied selects onto the mux select bus.
    always_comb begin
        clk_sel_o = '0;
        for (int n = 0; n < NUM_OUT; n++) begin
            clk_sel_o[n*SEL_W +: SEL_W] = applied[n];
        end
    end

endmodule

// File: tb/tb_pll_clk_switch_ctrl.sv
// tb_pll_clk_switch_ctrl
// Scoreboard bench: a timestamp-based reference model pushes expected responses
// at request acceptance; a negedge monitor pops on every ack and also compares
// lock, select and CE outputs each cycle. Directed scenarios then random traffic.
// Honours PLL_CFG_STICKY_UNLOCK_EN for STATUS bit31 expectations.
module tb_pll_clk_switch_ctrl;

    localparam int NO  = 2;
    localparam int NS  = 5;
    localparam int SW  = 3;
    localparam int RS  = 0;
    localparam int LC  = 16;
    localparam int G   = 4;
    localparam int S   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_lock;
    logic          cfg_req;
    logic          cfg_ack;
    logic [3:0]    cfg_add;
    logic          cfg_wrn;
    logic [31:0]   cfg_data;
    logic [31:0]   cfg_r_data;
    logic          cfg_lock;
    logic [NO*SW-1:0] clk_sel;
    logic [NO-1:0] clk_ce;

    int checks = 0;
    int errors = 0;

    pll_clk_switch_ctrl #(
        .NUM_OUT(NO), .NUM_SRC(NS), .SEL_W(SW), .RESET_SEL(RS),
        .LOCK_CNT(LC), .GATE_CYC(G), .SWITCH_CYC(S)
    ) dut (
        .ref_clk_i   (clk),
        .rst_glob_i  (rst),
        .pll_lock_i  (pll_lock),
        .cfg_req_i   (cfg_req),
        .cfg_ack_o   (cfg_ack),
        .cfg_add_i   (cfg_add),
        .cfg_wrn_i   (cfg_wrn),
        .cfg_data_i  (cfg_data),
        .cfg_r_data_o(cfg_r_data),
        .cfg_lock_o  (cfg_lock),
        .clk_sel_o   (clk_sel),
        .clk_ce_o    (clk_ce)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];
    resp_t popped;

    int cyc = 0;
    int run1 = 0;          // run length of high raw lock samples ending one edge ago
    int run2 = 0;          // same, two edges ago
    bit m_lock = 0;
    bit m_ack = 0;
    bit m_sticky = 0;
    int m_tgt   [NO] = '{default: RS};
    int m_app   [NO] = '{default: RS};
    int m_start [NO] = '{default: -1000};
    bit [NO-1:0] m_ce = '0;

    function automatic bit in_seq(input int start, input int t);
        return (t >= start) && (t < start + G + S);
    endfunction

    initial begin : model
        int    e;
        int    run_now;
        bit    lock_new;
        bit    acc;
        resp_t r;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cyc = 0; run1 = 0; run2 = 0;
                m_lock = 0; m_ack = 0; m_sticky = 0; m_ce = '0;
                for (int n = 0; n < NO; n++) begin
                    m_tgt[n] = RS; m_app[n] = RS; m_start[n] = -1000;
                end
                sb.delete();
            end else begin
                cyc++;
                e = cyc;
                // filtered lock = the 16 raw samples ending two edges ago were all high
                run_now  = pll_lock ? run1 + 1 : 0;
                lock_new = (run2 >= LC);
                run2 = run1;
                run1 = run_now;
                acc = cfg_req && !m_ack;
                if (acc) begin
                    r.is_read = cfg_wrn;
                    r.data    = '0;
                    if (cfg_add == 0) begin
                        r.data[0]  = m_lock;
                        for (int n = 0; n < NO; n++)
                            r.data[n+1] = in_seq(m_start[n], e - 1) || (m_tgt[n] != m_app[n]);
                        r.data[31] = m_sticky;
                    end else if (cfg_add <= NO) begin
                        r.data = m_tgt[cfg_add-1];
                    end
                    sb.push_back(r);
                end
                for (int n = 0; n < NO; n++) begin
                    if (!in_seq(m_start[n], e - 1) && m_tgt[n] != m_app[n] && m_lock)
                        m_start[n] = e;
                    if (e == m_start[n] + G)
                        m_app[n] = m_tgt[n];
                    m_ce[n] = m_lock && !in_seq(m_start[n], e);
                end
                if (acc && !cfg_wrn) begin
                    if (cfg_add >= 1 && cfg_add <= NO && cfg_data < NS)
                        m_tgt[cfg_add-1] = int'(cfg_data);
`ifdef PLL_CFG_STICKY_UNLOCK_EN
                    if (cfg_add == 0)
                        m_sticky = 0;
`endif
                end
`ifdef PLL_CFG_STICKY_UNLOCK_EN
                if (m_lock && !lock_new)
                    m_sticky = 1;
`endif
                m_lock = lock_new;
                m_ack  = acc;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [NO*SW-1:0] exp_sel;

    always @(negedge clk) begin
        for (int n = 0; n < NO; n++)
            exp_sel[n*SW +: SW] = SW'(m_app[n]);
        check("ack", {31'b0, cfg_ack}, {31'b0, m_ack});
        check("lock", {31'b0, cfg_lock}, {31'b0, m_lock});
        check("sel", {26'b0, clk_sel}, {26'b0, exp_sel});
        check("ce", {30'b0, clk_ce}, {30'b0, m_ce});
        if (cfg_ack) begin
            check("sb_nonempty", sb.size(), (sb.size() == 0) ? 1 : sb.size());
            if (sb.size() != 0) begin
                popped = sb.pop_front();
                if (popped.is_read)
                    check("rdata", cfg_r_data, popped.data);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one request; returns at the negedge where ack is seen.
    task automatic xact(input bit wrn, input logic [3:0] a, input logic [31:0] d);
        int k;
        cfg_req  = 1'b1;
        cfg_wrn  = wrn;
        cfg_add  = a;
        cfg_data = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cfg_ack && k < 8);
        if (!cfg_ack)
            check("ack_timeout", {31'b0, cfg_ack}, 32'd1);
        cfg_req = 1'b0;
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; pll_lock = 1'b0; cfg_req = 1'b0; cfg_wrn = 1'b1; cfg_add = '0; cfg_data = '0;
        wait_cyc(3);
        check("rst_ack", {31'b0, cfg_ack}, 0);
        check("rst_rdata", cfg_r_data, 0);
        check("rst_ce", {30'b0, clk_ce}, 0);
        check("rst_sel", {26'b0, clk_sel}, RS);
        rst = 1'b0;

        // lock acquisition latency
        @(negedge clk);
        pll_lock = 1'b1;
        n = 0;
        while (!cfg_lock && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lock_latency", n, 18);
        @(negedge clk);
        check("ce_after_lock", {30'b0, clk_ce}, 32'h3);
        check("sel_after_lock", {26'b0, clk_sel}, 0);

        // basic switch timing on channel 0
        xact(1'b0, 4'd1, 32'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) check("gate_ce0", {31'b0, clk_ce[0]}, 0);
            if (k == 4) check("sel_hold", {29'b0, clk_sel[2:0]}, 0);
            if (k == 5) check("sel_new", {29'b0, clk_sel[2:0]}, 3);
            if (k == 8) check("ce0_still_low", {31'b0, clk_ce[0]}, 0);
            if (k == 9) check("ce0_back", {31'b0, clk_ce[0]}, 1);
            check("ch1_ce", {31'b0, clk_ce[1]}, 1);
        end

        // STATUS busy during and after a sequence
        xact(1'b0, 4'd1, 32'd1);
        xact(1'b1, 4'd0, 32'd0);
        check("status_busy", {31'b0, cfg_r_data[1]}, 1);
        wait_cyc(12);
        xact(1'b1, 4'd0, 32'd0);
        check("status_idle", cfg_r_data, 32'h1);

        // out-of-range write dropped; same-value write starts nothing
        xact(1'b0, 4'd1, 32'd7);
        xact(1'b1, 4'd1, 32'd0);
        check("sel_rb_unchanged", cfg_r_data, 32'd1);
        xact(1'b0, 4'd1, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("no_drop", {31'b0, clk_ce[0]}, 1);
        end

        // write during GATE then during SWITCH
        xact(1'b0, 4'd1, 32'd0);
        xact(1'b0, 4'd1, 32'd2);
        wait_cyc(3);
        check("gate_latched", {29'b0, clk_sel[2:0]}, 2);
        xact(1'b0, 4'd1, 32'd4);
        wait_cyc(25);
        check("second_seq", {29'b0, clk_sel[2:0]}, 4);

        // one-cycle lock glitch
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 2)  check("glitch_lock_low", {31'b0, cfg_lock}, 0);
            if (k == 3)  check("glitch_ce_low", {30'b0, clk_ce}, 0);
            if (k == 17) check("glitch_lock_wait", {31'b0, cfg_lock}, 0);
            if (k == 18) check("glitch_relock", {31'b0, cfg_lock}, 1);
            if (k == 19) check("glitch_ce_back", {30'b0, clk_ce}, 32'h3);
        end
        xact(1'b1, 4'd0, 32'd0);
`ifdef PLL_CFG_STICKY_UNLOCK_EN
        check("sticky_set", {31'b0, cfg_r_data[31]}, 1);
        xact(1'b0, 4'd0, 32'd0);
        xact(1'b1, 4'd0, 32'd0);
        check("sticky_clr", {31'b0, cfg_r_data[31]}, 0);
`else
        check("sticky_off", {31'b0, cfg_r_data[31]}, 0);
`endif

        // reset in the middle of a SWITCH phase on channel 1
        xact(1'b0, 4'd2, 32'd3);
        wait_cyc(6);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ack", {31'b0, cfg_ack}, 0);
        check("mid_rst_rdata", cfg_r_data, 0);
        check("mid_rst_lock", {31'b0, cfg_lock}, 0);
        check("mid_rst_ce", {30'b0, clk_ce}, 0);
        check("mid_rst_sel", {26'b0, clk_sel}, RS);
        @(negedge clk);
        rst = 1'b0;
        cfg_req = 1'b1; cfg_wrn = 1'b1; cfg_add = 4'd2;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("ack_toggle", {31'b0, cfg_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        cfg_req = 1'b0;

        // random traffic
        wait_cyc(25);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                pll_lock = 1'b0;
                wait_cyc($urandom_range(1, 3));
                pll_lock = 1'b1;
            end else begin
                xact(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)),
                     ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7)));
            end
            wait_cyc($urandom_range(0, 12));
        end
        wait_cyc(30);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
